// File: rtl/apb_reg_completer.sv
// apb_reg_completer: APB4 completer backed by a bank of byte-writable 32-bit
// registers, with programmable wait states and error flagging.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata, pstrb     byte address, write data, byte strobes
//   pprot                    protection (bit 0 = privileged)
//   pready, pslverr, prdata  registered completion, error and read data
module apb_reg_completer #(
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned PRIV_BASE   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDRWIDTH-1:0]   paddr,
  input  logic [DATAWIDTH-1:0]   pwdata,
  input  logic [DATAWIDTH/8-1:0] pstrb,
  input  logic [2:0]             pprot,
  output logic                   pready,
  output logic                   pslverr,
  output logic [DATAWIDTH-1:0]   prdata
);
  localparam int unsigned IDXW  = $clog2(NUM_REGS);
  localparam int unsigned STRBW = DATAWIDTH / 8;
  localparam int unsigned CNTW  = 4;

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic [STRBW-1:0]       strb_q, strb_d;
  logic                   err_q, err_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [DATAWIDTH-1:0]   prdata_q, prdata_d;
  logic [DATAWIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATAWIDTH-1:0]   regs_d [NUM_REGS];

  // Setup-phase decode of the live bus
  logic                   setup;
  logic [IDXW-1:0]        setup_idx;
  logic                   setup_err;
  logic [DATAWIDTH-1:0]   setup_rdata;
  logic [DATAWIDTH-1:0]   acc_rdata;
  logic                   commit;
  logic                   unused_pprot;

  assign setup     = psel && !penable;
  assign setup_idx = paddr[2 +: IDXW];
  // Misaligned, above the register bank, or unprivileged write to a protected index
  assign setup_err = (|paddr[1:0])
                  || (|paddr[ADDRWIDTH-1:IDXW+2])
                  || (pwrite && !pprot[0] && (32'(setup_idx) >= PRIV_BASE));
  assign setup_rdata  = (pwrite || setup_err) ? '0 : regs_q[setup_idx];
  assign acc_rdata    = (write_q || err_q) ? '0 : regs_q[idx_q];
  assign commit       = (state_q == S_ACCESS) && pready_q && psel && penable
                        && write_q && !err_q;
  assign unused_pprot = ^pprot[2:1];

  // Next-state, capture, response and register-update logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    regs_d    = regs_q;

    case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = S_ACCESS;
          cnt_d   = CNTW'(WAIT_CYCLES);
          write_d = pwrite;
          idx_d   = setup_idx;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = setup_err;
          // Zero-wait: the response must already be up in the first access cycle
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = setup_rdata;
          end
        end
      end
      S_ACCESS: begin
        if (pready_q) begin
          state_d = S_IDLE;
          if (commit) begin
            for (int unsigned b = 0; b < STRBW; b++) begin
              if (strb_q[b]) regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
            end
          end
        end else if (!psel) begin
          // Abort: drop the transfer without a response
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (penable && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNTW'(1);
          // Last wait state: launch the registered response
          if (cnt_q == CNTW'(1)) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = acc_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and storage registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb_apb_reg_completer: three completers (0, 1 and 3 wait states) on a shared
// APB bus with per-instance psel. The driver pushes expected responses into a
// queue; a negedge monitor pops and compares whenever any pready is high.
module tb_apb_reg_completer;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready_w  [3];
  logic        pslverr_w [3];
  logic [31:0] prdata_w  [3];

  int cyc = 0;
  int checks_n = 0;
  int fails_n = 0;

  typedef struct {
    int          dut;
    bit          wr;
    logic [31:0] rd;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_reg_completer #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[0]), .pslverr(pslverr_w[0]), .prdata(prdata_w[0]));

  apb_reg_completer #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[1]), .pslverr(pslverr_w[1]), .prdata(prdata_w[1]));

  apb_reg_completer #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_w[2]), .pslverr(pslverr_w[2]), .prdata(prdata_w[2]));

  function automatic int waits(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      fails_n++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare every completion against the scoreboard, idle outputs against 0
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        if (pready_w[d]) begin
          if (sb.size() == 0) begin
            checks_n++;
            fails_n++;
            $display("FAIL unexpected_pready: dut %0d got pready=1 expected 0 (cycle %0d)", d, cyc);
          end else begin
            mon_e = sb.pop_front();
            chk("resp_dut", 32'(d), 32'(mon_e.dut));
            chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("pslverr", 32'(pslverr_w[d]), 32'(mon_e.err));
            if (!mon_e.wr) chk("prdata", prdata_w[d], mon_e.rd);
          end
        end else begin
          chk("idle_pslverr", 32'(pslverr_w[d]), 32'd0);
          chk("idle_prdata", prdata_w[d], 32'd0);
        end
      end
    end
  end

  // One APB transfer; called and returning at a cycle start (posedge + 1)
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input logic [31:0] erd, input bit eerr);
    exp_t e;
    int   n;
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    pstrb     = st;
    pprot     = pr;
    e.dut = d; e.wr = wr; e.rd = erd; e.err = eerr; e.cyc = cyc + 1 + waits(d);
    sb.push_back(e);
    @(posedge clk); #1;
    // Captured at setup: scrambling these now must not matter
    penable = 1'b1;
    pwdata  = ~wd;
    pstrb   = ~st;
    pprot   = ~pr;
    n = 0;
    while (!pready_w[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pready_w[d]) begin
      checks_n++;
      fails_n++;
      $display("FAIL timeout: dut %0d addr %h got no pready expected one", d, a);
      void'(sb.pop_back());
    end else begin
      @(posedge clk); #1;
    end
    psel_v  = '0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation got stuck expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; psel_v = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", 32'(pready_w[d]), 32'd0);
      chk("rst_pslverr", 32'(pslverr_w[d]), 32'd0);
      chk("rst_prdata", prdata_w[d], 32'd0);
    end
    rst = 1'b1;

    // Basic, strobe and error cases on the 1-wait instance
    xfer(1, 1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0, 0);
    xfer(1, 0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0);
    xfer(1, 1, 32'h08, 32'h11223344, 4'hF, 3'b001, 32'h0, 0);
    xfer(1, 1, 32'h08, 32'hAABBCCDD, 4'h5, 3'b001, 32'h0, 0);
    xfer(1, 0, 32'h08, 32'h0,        4'h0, 3'b000, 32'h11BB33DD, 0);
    xfer(1, 0, 32'h40, 32'h0,        4'h0, 3'b001, 32'h0, 1);
    xfer(1, 1, 32'h06, 32'hFFFFFFFF, 4'hF, 3'b001, 32'h0, 1);
    xfer(1, 0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0);
    xfer(1, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1);
    xfer(1, 0, 32'h20, 32'h0,        4'h0, 3'b000, 32'h0, 0);
    xfer(1, 1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b001, 32'h0, 0);
    xfer(1, 0, 32'h20, 32'h0,        4'h0, 3'b000, 32'hCAFEF00D, 0);
    xfer(1, 1, 32'h04, 32'h00000000, 4'h0, 3'b001, 32'h0, 0);
    xfer(1, 0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 0);
    xfer(1, 1, 32'h3C, 32'h55AA55AA, 4'hF, 3'b000, 32'h0, 1);
    xfer(1, 0, 32'h3C, 32'h0,        4'h0, 3'b000, 32'h0, 0);
    xfer(1, 1, 32'h1C, 32'h76543210, 4'hF, 3'b000, 32'h0, 0);
    xfer(1, 0, 32'h1C, 32'h0,        4'h0, 3'b000, 32'h76543210, 0);
    xfer(1, 0, 32'h41, 32'h0,        4'h0, 3'b000, 32'h0, 1);

    // Back-to-back on the 0-wait and 3-wait instances
    for (int i = 0; i < 8; i++)
      xfer(0, 1, 32'(4*i), 32'h11111111 * 32'(i+1), 4'hF, 3'b000, 32'h0, 0);
    for (int i = 0; i < 8; i++)
      xfer(0, 0, 32'(4*i), 32'h0, 4'h0, 3'b000, 32'h11111111 * 32'(i+1), 0);
    for (int i = 0; i < 8; i++)
      xfer(2, 1, 32'(4*i), 32'hF0F00000 + 32'(i), 4'hF, 3'b000, 32'h0, 0);
    for (int i = 0; i < 8; i++)
      xfer(2, 0, 32'(4*i), 32'h0, 4'h0, 3'b000, 32'hF0F00000 + 32'(i), 0);
    xfer(0, 0, 32'h40, 32'h0, 4'h0, 3'b000, 32'h0, 1);

    // Abort on the 3-wait instance: psel dropped after the first access cycle
    xfer(2, 1, 32'h0C, 32'h12345678, 4'hF, 3'b001, 32'h0, 0);
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_v = '0; penable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    xfer(2, 0, 32'h0C, 32'h0, 4'h0, 3'b000, 32'h12345678, 0);

    // Reset while the 1-wait instance is completing and the 3-wait one is waiting
    psel_v = 3'b110; penable = 1'b0; pwrite = 1'b0; paddr = 32'h04; pprot = 3'b000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_pready", 32'(pready_w[1]), 32'd1);
    chk("pre_rst_prdata", prdata_w[1], 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    for (int d = 1; d < 3; d++) begin
      chk("async_rst_pready", 32'(pready_w[d]), 32'd0);
      chk("async_rst_pslverr", 32'(pslverr_w[d]), 32'd0);
      chk("async_rst_prdata", prdata_w[d], 32'd0);
    end
    psel_v = '0; penable = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    xfer(1, 0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(1, 0, 32'h08, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(2, 0, 32'h00, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(2, 0, 32'h04, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(0, 0, 32'h1C, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(2, 1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'b000, 32'h0, 0);
    xfer(2, 0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hA5A5A5A5, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks_n, fails_n);
    $finish;
  end
endmodule
